itch_frame_loader: RTL

//  Sequencer in front of the ITCH parser. Accepts a framed stream of 32-bit ITCH words,

---
 rtl/itch_frame_loader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/itch_frame_loader.sv
// Frame loader in front of the ITCH parser: assembles stream words into the 8-register
// message bank, filters bad types and overlong frames, and issues when the book is idle.
module itch_frame_loader #(
  parameter int REG_WIDTH = 32,
  parameter int NUM_REGS  = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [REG_WIDTH-1:0] i_word,
  input  logic                 i_word_valid,
  input  logic                 i_word_last,
  output logic                 o_word_ready,
  input  logic                 i_book_is_busy,
  output logic [REG_WIDTH-1:0] o_reg_1,
  output logic [REG_WIDTH-1:0] o_reg_2,
  output logic [REG_WIDTH-1:0] o_reg_3,
  output logic [REG_WIDTH-1:0] o_reg_4,
  output logic [REG_WIDTH-1:0] o_reg_5,
  output logic [REG_WIDTH-1:0] o_reg_6,
  output logic [REG_WIDTH-1:0] o_reg_7,
  output logic [REG_WIDTH-1:0] o_reg_8,
  output logic                 o_msg_valid,
  output logic [CNT_WIDTH-1:0] o_issued_count,
  output logic [CNT_WIDTH-1:0] o_dropped_count
);

  localparam int IDX_W = $clog2(NUM_REGS + 1);

  typedef enum logic [1:0] {FILL, DISCARD, HOLD} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [REG_WIDTH-1:0]   bank_q [NUM_REGS];
  logic [REG_WIDTH-1:0]   bank_d [NUM_REGS];
  logic                   msg_valid_q, msg_valid_d;
  logic [CNT_WIDTH-1:0]   issued_q, issued_d;
  logic [CNT_WIDTH-1:0]   dropped_q, dropped_d;

  logic       word_ready;
  logic       accept;
  logic [7:0] msg_type;
  logic       type_ok;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign word_ready = (state_q != HOLD);
  assign accept     = i_word_valid & word_ready;
  assign msg_type   = i_word[REG_WIDTH-1 -: 8];
  assign type_ok    = (msg_type == 8'h41) || (msg_type == 8'h58) || (msg_type == 8'h45);

  // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    bank_d      = bank_q;
    msg_valid_d = 1'b0;
    issued_d    = issued_q;
    dropped_d   = dropped_q;

    case (state_q)
      FILL: begin
        if (accept) begin
          if (idx_q == '0) begin
            if (type_ok) begin
              bank_d[0] = i_word;
              for (int k = 1; k < NUM_REGS; k++) bank_d[k] = '0;
              if (i_word_last) state_d = HOLD;
              else             idx_d   = IDX_W'(1);
            end else if (i_word_last) begin
              dropped_d = sat_inc(dropped_q);
            end else begin
              state_d = DISCARD;
            end
          end else if (idx_q == IDX_W'(NUM_REGS)) begin
            // Overlong: the bank already holds a partial frame but it is never issued.
            idx_d = '0;
            if (i_word_last) dropped_d = sat_inc(dropped_q);
            else             state_d   = DISCARD;
          end else begin
            for (int k = 1; k < NUM_REGS; k++)
              if (idx_q == IDX_W'(k)) bank_d[k] = i_word;
            if (i_word_last) begin
              state_d = HOLD;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + IDX_W'(1);
            end
          end
        end
      end

      DISCARD: begin
        idx_d = '0;
        if (accept && i_word_last) begin
          dropped_d = sat_inc(dropped_q);
          state_d   = FILL;
        end
      end

      HOLD: begin
        if (!i_book_is_busy) begin
          msg_valid_d = 1'b1;
          issued_d    = sat_inc(issued_q);
          state_d     = FILL;
        end
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= FILL;
      idx_q       <= '0;
      msg_valid_q <= 1'b0;
      issued_q    <= '0;
      dropped_q   <= '0;
      // NOTE: the bank is reset on purpose; it drives parser-visible ports that must read zero.
      for (int k = 0; k < NUM_REGS; k++) bank_q[k] <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      msg_valid_q <= msg_valid_d;
      issued_q    <= issued_d;
      dropped_q   <= dropped_d;
      bank_q      <= bank_d;
    end
  end

  assign o_word_ready    = word_ready;
  assign o_msg_valid     = msg_valid_q;
  assign o_issued_count  = issued_q;
  assign o_dropped_count = dropped_q;
  assign o_reg_1 = bank_q[0];
  assign o_reg_2 = bank_q[1];
  assign o_reg_3 = bank_q[2];
  assign o_reg_4 = bank_q[3];
  assign o_reg_5 = bank_q[4];
  assign o_reg_6 = bank_q[5];
  assign o_reg_7 = bank_q[6];
  assign o_reg_8 = bank_q[7];

endmodule
